id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register directly downstream of the register file. Captures rs/rt read data, immediate and control.
//  Detects load-use hazards, inserts one bubble and stalls PC/IF-ID; bypasses same-cycle WB writes into rs/rt data.
//  Supports branch flush and a downstream hold (memory busy). Counts inserted bubbles for performance debug.
// PARAMETERS
//  DW   32  datapath width (register data, immediate)
//  AW   5   register address width
//  CW   16  bubble counter width (saturating)
// PORTS
//  clk_i          in   1   clock, all state updates on rising edge
//  rst_i          in   1   asynchronous, active-low reset
//  id_valid_i     in   1   ID holds a real instruction
//  id_rsaddr_i    in   AW  rs address (same value driven to register file)
//  id_rtaddr_i    in   AW  rt address
//  id_rdaddr_i    in   AW  rd address
//  id_rsdata_i    in   DW  rs data from register file
//  id_rtdata_i    in   DW  rt data from register file
//  id_imm_i       in   DW  sign-extended immediate
//  id_ctrl_i      in   8   {regwrite,memtoreg,memread,memwrite,alusrc,regdst,aluop[1:0]}
//  wb_regwrite_i  in   1   WB stage writes register file this cycle
//  wb_addr_i      in   AW  WB destination
//  wb_data_i      in   DW  WB data
//  flush_i        in   1   branch taken: squash ID instruction
//  hold_i         in   1   downstream busy: freeze ID/EX
//  stall_o        out  1   freeze PC and IF/ID this cycle (comb.)
//  ex_valid_o     out  1   EX holds a real instruction
//  ex_rsaddr_o / ex_rtaddr_o / ex_rdaddr_o  out AW  registered addresses
//  ex_rsdata_o / ex_rtdata_o  out DW  registered (bypassed) operands
//  ex_imm_o       out  DW  registered immediate
//  ex_ctrl_o      out  8   registered control, all zero when bubble
//  bubble_cnt_o   out  CW  number of bubbles inserted, saturates at all-ones
// BEHAVIOUR
//  Reset (rst_i=0, async): all ex_* outputs 0, ex_valid_o=0, bubble_cnt_o=0, FSM=RUN; stall_o follows comb. rules.
//  Bypass (comb.): rs_byp = (wb_regwrite_i && wb_addr_i!=0 && wb_addr_i==id_rsaddr_i) ? wb_data_i : id_rsdata_i; same for rt.
//  Load-use hit (comb.): ex_valid_o && ex_ctrl_o.memread && ex_rtaddr_o!=0 && id_valid_i &&
//    (ex_rtaddr_o==id_rsaddr_i || ex_rtaddr_o==id_rtaddr_i).
//  FSM states RUN, BUBBLE, HOLD; priority per edge: hold_i > flush_i > load-use > normal capture.
//   RUN: hold_i -> HOLD, regs unchanged. flush_i -> load zeros (ex_valid_o=0), stay RUN.
//        load-use -> load zeros, bubble_cnt_o+1 (saturating), -> BUBBLE. else capture ID fields, stay RUN.
//   BUBBLE: one cycle only; ID re-presented, hazard gone -> capture normally, -> RUN (hold_i/flush_i as RUN).
//   HOLD: regs frozen while hold_i=1; on hold_i=0 -> RUN, next edge evaluated as RUN.
//  stall_o = hold_i | (load-use & ~flush_i). Flush wins over load-use: squashed instr needs no bubble.
//  Latency: ID fields appear on ex_* exactly 1 cycle after capture edge.
//  Register 0: never bypassed, never causes load-use; bypass only substitutes data, addresses pass unchanged.
//  Bubble = ex_valid_o=0 and ex_ctrl_o=0 (no regwrite/memwrite side effects); data/addr fields also zeroed.
//  Frozen cycles (HOLD) do not re-sample bypass; operand captured at original capture edge stays.
//  Reset mid-stall: returns to RUN with empty EX; no pending bubble retained.
// STRUCTURE
//  Shared package: control bit index constants (CTRL_REGWRITE..CTRL_ALUOP), CTRL_W=8, FSM state encodings.
//  One sub-module: hazard_detect (purely comb. load-use compare + stall_o); bypass muxes and regs stay in top.
// TESTING
//  1 reset asserted mid-run -> all ex_* 0, bubble_cnt_o=0 immediately (async), FSM RUN after release.
//  2 lw $2 in EX, ID add rs=2 -> stall_o=1 one cycle, ex_ctrl_o=0 next, then add captured; bubble_cnt_o=1.
//  3 wb writes $5=0xDEADBEEF, ID rs=5 reads stale 0 -> ex_rsdata_o=0xDEADBEEF; wb_addr_i=0 -> no bypass.
//  4 load-use and flush_i same cycle -> stall_o=0, bubble inserted, bubble_cnt_o unchanged.
//  5 hold_i high 3 cycles with lw in EX -> ex_* stable 3 cycles, stall_o=1; release resumes RUN, hazard then handled.
//  6 force bubble_cnt_o=0xFFFE, three load-use bubbles -> saturates at 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage: control-word bit layout
// and the stage FSM/action encodings.
package id_ex_stage_pkg;

    localparam int CTRL_W        = 8;
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_REGDST   = 2;
    localparam int CTRL_ALUOP    = 0;
    localparam int CTRL_ALUOP_W  = 2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // What the ID/EX register does on the coming edge.
    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_ZERO    = 2'd1,
        ACT_KEEP    = 2'd2
    } act_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: ID-side operands, WB write port, pipeline control
// and the registered EX-side view.
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) ();

    logic              id_valid_i;
    logic [AW-1:0]     id_rsaddr_i;
    logic [AW-1:0]     id_rtaddr_i;
    logic [AW-1:0]     id_rdaddr_i;
    logic [DW-1:0]     id_rsdata_i;
    logic [DW-1:0]     id_rtdata_i;
    logic [DW-1:0]     id_imm_i;
    logic [CTRL_W-1:0] id_ctrl_i;
    logic              wb_regwrite_i;
    logic [AW-1:0]     wb_addr_i;
    logic [DW-1:0]     wb_data_i;
    logic              flush_i;
    logic              hold_i;

    logic              stall_o;
    logic              ex_valid_o;
    logic [AW-1:0]     ex_rsaddr_o;
    logic [AW-1:0]     ex_rtaddr_o;
    logic [AW-1:0]     ex_rdaddr_o;
    logic [DW-1:0]     ex_rsdata_o;
    logic [DW-1:0]     ex_rtdata_o;
    logic [DW-1:0]     ex_imm_o;
    logic [CTRL_W-1:0] ex_ctrl_o;
    logic [CW-1:0]     bubble_cnt_o;

    modport master (
        output id_valid_i, id_rsaddr_i, id_rtaddr_i, id_rdaddr_i,
               id_rsdata_i, id_rtdata_i, id_imm_i, id_ctrl_i,
               wb_regwrite_i, wb_addr_i, wb_data_i, flush_i, hold_i,
        input  stall_o, ex_valid_o, ex_rsaddr_o, ex_rtaddr_o, ex_rdaddr_o,
               ex_rsdata_o, ex_rtdata_o, ex_imm_o, ex_ctrl_o, bubble_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rsaddr_i, id_rtaddr_i, id_rdaddr_i,
               id_rsdata_i, id_rtdata_i, id_imm_i, id_ctrl_i,
               wb_regwrite_i, wb_addr_i, wb_data_i, flush_i, hold_i,
        output stall_o, ex_valid_o, ex_rsaddr_o, ex_rtaddr_o, ex_rdaddr_o,
               ex_rsdata_o, ex_rtdata_o, ex_imm_o, ex_ctrl_o, bubble_cnt_o
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard compare between the load in EX and the instruction in ID,
// plus the front-end stall request. Purely combinational.
module hazard_detect #(
    parameter int AW = 5
) (
    input  logic          ex_valid,
    input  logic          ex_memread,
    input  logic [AW-1:0] ex_rtaddr,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rsaddr,
    input  logic [AW-1:0] id_rtaddr,
    input  logic          flush,
    input  logic          hold,
    output logic          load_use,
    output logic          stall
);

    assign load_use = ex_valid && ex_memread && (ex_rtaddr != '0) && id_valid &&
                      ((ex_rtaddr == id_rsaddr) || (ex_rtaddr == id_rtaddr));

    // A squashed ID instruction never needs its bubble, so flush masks the hazard.
    assign stall = hold | (load_use & ~flush);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB->ID operand bypass, one-cycle load-use
// bubble insertion, branch flush, downstream hold and a saturating bubble counter.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 16
) (
    input logic           clk_i,
    input logic           rst_i,
    id_ex_stage_if.slave  bus
);

    typedef struct packed {
        logic              valid;
        logic [AW-1:0]     rs;
        logic [AW-1:0]     rt;
        logic [AW-1:0]     rd;
        logic [DW-1:0]     rsd;
        logic [DW-1:0]     rtd;
        logic [DW-1:0]     imm;
        logic [CTRL_W-1:0] ctrl;
    } ex_t;

    ex_t           ex_q;
    ex_t           id_fields;
    logic [DW-1:0] rs_byp;
    logic [DW-1:0] rt_byp;
    logic [CW-1:0] cnt_q;
    logic          load_use;
    logic          cnt_inc;
    state_e        state_q;
    state_e        state_d;
    act_e          act;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rs_byp = bus.id_rsdata_i;
        rt_byp = bus.id_rtdata_i;
        if (bus.wb_regwrite_i && (bus.wb_addr_i != '0)) begin
            if (bus.wb_addr_i == bus.id_rsaddr_i) rs_byp = bus.wb_data_i;
            if (bus.wb_addr_i == bus.id_rtaddr_i) rt_byp = bus.wb_data_i;
        end
    end

    assign id_fields = '{valid: bus.id_valid_i,
                         rs:    bus.id_rsaddr_i,
                         rt:    bus.id_rtaddr_i,
                         rd:    bus.id_rdaddr_i,
                         rsd:   rs_byp,
                         rtd:   rt_byp,
                         imm:   bus.id_imm_i,
                         ctrl:  bus.id_ctrl_i};

    hazard_detect #(.AW(AW)) u_hazard (
        .ex_valid   (ex_q.valid),
        .ex_memread (ex_q.ctrl[CTRL_MEMREAD]),
        .ex_rtaddr  (ex_q.rt),
        .id_valid   (bus.id_valid_i),
        .id_rsaddr  (bus.id_rsaddr_i),
        .id_rtaddr  (bus.id_rtaddr_i),
        .flush      (bus.flush_i),
        .hold       (bus.hold_i),
        .load_use   (load_use),
        .stall      (bus.stall_o)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // BUBBLE leaves EX empty (no hazard possible) and the HOLD release edge
    // must capture, so every state applies the same edge priority.
    always_comb begin
        state_d = state_q;
        if (bus.hold_i)       state_d = ST_HOLD;
        else if (bus.flush_i) state_d = ST_RUN;
        else if (load_use)    state_d = ST_BUBBLE;
        else                  state_d = ST_RUN;
    end

    always_comb begin
        act     = ACT_CAPTURE;
        cnt_inc = 1'b0;
        if (bus.hold_i) begin
            act = ACT_KEEP;
        end else if (bus.flush_i) begin
            act = ACT_ZERO;
        end else if (load_use) begin
            act     = ACT_ZERO;
            cnt_inc = 1'b1;
        end
    end

    // NOTE: pipeline registers are reset so EX never starts with a phantom instruction; there is no array storage here to reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q <= '0;
        end else begin
            unique case (act)
                ACT_CAPTURE: ex_q <= id_fields;
                ACT_ZERO:    ex_q <= '0;
                default:     ex_q <= ex_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                         cnt_q <= '0;
        else if (cnt_inc && (cnt_q != '1))  cnt_q <= cnt_q + 1'b1;
    end

    assign bus.ex_valid_o   = ex_q.valid;
    assign bus.ex_rsaddr_o  = ex_q.rs;
    assign bus.ex_rtaddr_o  = ex_q.rt;
    assign bus.ex_rdaddr_o  = ex_q.rd;
    assign bus.ex_rsdata_o  = ex_q.rsd;
    assign bus.ex_rtdata_o  = ex_q.rtd;
    assign bus.ex_imm_o     = ex_q.imm;
    assign bus.ex_ctrl_o    = ex_q.ctrl;
    assign bus.bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; a second instance with a 2-bit counter
// follows the same stimulus to reach counter saturation quickly.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic [7:0]  ctrl;
    } fld_t;

    localparam logic [7:0] LW  = 8'hE8;  // regwrite, memtoreg, memread, alusrc
    localparam logic [7:0] ADD = 8'h86;  // regwrite, regdst, aluop=10
    localparam int SAT_MAX = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(32), .AW(5), .CW(16)) bus ();
    id_ex_stage_if #(.DW(32), .AW(5), .CW(2))  sat_bus ();

    assign sat_bus.id_valid_i    = bus.id_valid_i;
    assign sat_bus.id_rsaddr_i   = bus.id_rsaddr_i;
    assign sat_bus.id_rtaddr_i   = bus.id_rtaddr_i;
    assign sat_bus.id_rdaddr_i   = bus.id_rdaddr_i;
    assign sat_bus.id_rsdata_i   = bus.id_rsdata_i;
    assign sat_bus.id_rtdata_i   = bus.id_rtdata_i;
    assign sat_bus.id_imm_i      = bus.id_imm_i;
    assign sat_bus.id_ctrl_i     = bus.id_ctrl_i;
    assign sat_bus.wb_regwrite_i = bus.wb_regwrite_i;
    assign sat_bus.wb_addr_i     = bus.wb_addr_i;
    assign sat_bus.wb_data_i     = bus.wb_data_i;
    assign sat_bus.flush_i       = bus.flush_i;
    assign sat_bus.hold_i        = bus.hold_i;

    id_ex_stage #(.DW(32), .AW(5), .CW(16)) dut (
        .clk_i (clk), .rst_i (rst_n), .bus (bus.slave));
    id_ex_stage #(.DW(32), .AW(5), .CW(2)) dut_sat (
        .clk_i (clk), .rst_i (rst_n), .bus (sat_bus.slave));

    fld_t ex_act, sat_ex_act;
    assign ex_act = {bus.ex_valid_o, bus.ex_rsaddr_o, bus.ex_rtaddr_o, bus.ex_rdaddr_o,
                     bus.ex_rsdata_o, bus.ex_rtdata_o, bus.ex_imm_o, bus.ex_ctrl_o};
    assign sat_ex_act = {sat_bus.ex_valid_o, sat_bus.ex_rsaddr_o, sat_bus.ex_rtaddr_o,
                         sat_bus.ex_rdaddr_o, sat_bus.ex_rsdata_o, sat_bus.ex_rtdata_o,
                         sat_bus.ex_imm_o, sat_bus.ex_ctrl_o};

    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;
    fld_t exp_q[$];

    function automatic fld_t fld(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [31:0] rsd,
                                 input logic [31:0] rtd, input logic [31:0] imm,
                                 input logic [7:0] ctrl);
        fld_t f;
        f = '{valid: v, rs: rs, rt: rt, rd: rd, rsd: rsd, rtd: rtd, imm: imm, ctrl: ctrl};
        return f;
    endfunction

    task automatic set_side(input logic wbw, input logic [4:0] wba, input logic [31:0] wbd,
                            input logic flush, input logic hold);
        bus.wb_regwrite_i = wbw;
        bus.wb_addr_i     = wba;
        bus.wb_data_i     = wbd;
        bus.flush_i       = flush;
        bus.hold_i        = hold;
    endtask

    task automatic drive_id(input fld_t id);
        bus.id_valid_i  = id.valid;
        bus.id_rsaddr_i = id.rs;
        bus.id_rtaddr_i = id.rt;
        bus.id_rdaddr_i = id.rd;
        bus.id_rsdata_i = id.rsd;
        bus.id_rtdata_i = id.rtd;
        bus.id_imm_i    = id.imm;
        bus.id_ctrl_i   = id.ctrl;
    endtask

    // One pipeline step: drive ID, queue the expected EX contents, check the
    // combinational stall mid-cycle, then pop and compare after the edge.
    task automatic cycle(input string name, input fld_t id, input fld_t exp_ex,
                         input logic exp_stall);
        fld_t e;
        drive_id(id);
        exp_q.push_back(exp_ex);
        @(negedge clk);
        checks++;
        if (bus.stall_o !== exp_stall) begin
            errors++;
            $display("FAIL %s stall_o: got %b want %b", name, bus.stall_o, exp_stall);
        end
        checks++;
        if (sat_bus.stall_o !== exp_stall) begin
            errors++;
            $display("FAIL %s sat stall_o: got %b want %b", name, sat_bus.stall_o, exp_stall);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (ex_act !== e) begin
            errors++;
            $display("FAIL %s ex: got %h want %h", name, ex_act, e);
        end
        checks++;
        if (sat_ex_act !== e) begin
            errors++;
            $display("FAIL %s sat ex: got %h want %h", name, sat_ex_act, e);
        end
    endtask

    task automatic check_cnt(input string name);
        int sat_exp;
        sat_exp = (exp_cnt > SAT_MAX) ? SAT_MAX : exp_cnt;
        checks++;
        if (bus.bubble_cnt_o !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL %s bubble_cnt: got %0d want %0d", name, bus.bubble_cnt_o, exp_cnt);
        end
        checks++;
        if (sat_bus.bubble_cnt_o !== 2'(sat_exp)) begin
            errors++;
            $display("FAIL %s sat bubble_cnt: got %0d want %0d", name, sat_bus.bubble_cnt_o, sat_exp);
        end
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (ex_act !== fld_t'('0)) begin
            errors++;
            $display("FAIL %s ex: got %h want 0", name, ex_act);
        end
        checks++;
        if (sat_ex_act !== fld_t'('0)) begin
            errors++;
            $display("FAIL %s sat ex: got %h want 0", name, sat_ex_act);
        end
        checks++;
        if (bus.stall_o !== 1'b0) begin
            errors++;
            $display("FAIL %s stall_o: got %b want 0", name, bus.stall_o);
        end
        check_cnt(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_side(0, 0, 0, 0, 0);
        drive_id('0);
        #2;
        exp_cnt = 0;
        check_empty("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_load_use();
        fld_t lw1, add1, lw2, add2;
        lw1  = fld(1, 1, 2, 0, 32'h100, 32'h0, 32'h4, LW);
        add1 = fld(1, 2, 3, 4, 32'h11, 32'h22, 32'h0, ADD);
        cycle("lu_lw_rs", lw1, lw1, 0);
        cycle("lu_bubble_rs", add1, '0, 1);
        exp_cnt++;
        check_cnt("lu_bubble_rs");
        cycle("lu_capture_rs", add1, add1, 0);
        check_cnt("lu_capture_rs");
        lw2  = fld(1, 1, 7, 0, 32'h200, 32'h0, 32'h8, LW);
        add2 = fld(1, 3, 7, 5, 32'h33, 32'h44, 32'h0, ADD);
        cycle("lu_lw_rt", lw2, lw2, 0);
        cycle("lu_bubble_rt", add2, '0, 1);
        exp_cnt++;
        cycle("lu_capture_rt", add2, add2, 0);
        check_cnt("lu_rt");
    endtask

    task automatic test_reg0();
        fld_t lw0, add0, lw9, inv9;
        lw0  = fld(1, 1, 0, 0, 32'h300, 32'h0, 32'h0, LW);
        add0 = fld(1, 0, 0, 6, 32'h0, 32'h0, 32'h0, ADD);
        cycle("r0_lw", lw0, lw0, 0);
        cycle("r0_no_hazard", add0, add0, 0);
        lw9  = fld(1, 1, 9, 0, 32'h400, 32'h0, 32'h0, LW);
        inv9 = fld(0, 9, 9, 0, 32'h0, 32'h0, 32'h0, 8'h0);
        cycle("inv_lw", lw9, lw9, 0);
        cycle("inv_no_hazard", inv9, inv9, 0);
        check_cnt("reg0");
    endtask

    task automatic test_bypass();
        set_side(1, 5, 32'hDEADBEEF, 0, 0);
        cycle("byp_rs", fld(1, 5, 6, 7, 32'h0, 32'h66, 32'h0, ADD),
              fld(1, 5, 6, 7, 32'hDEADBEEF, 32'h66, 32'h0, ADD), 0);
        set_side(1, 0, 32'h12345678, 0, 0);
        cycle("byp_addr0", fld(1, 0, 6, 7, 32'h0, 32'h66, 32'h0, ADD),
              fld(1, 0, 6, 7, 32'h0, 32'h66, 32'h0, ADD), 0);
        set_side(1, 6, 32'hCAFEF00D, 0, 0);
        cycle("byp_rt", fld(1, 0, 6, 7, 32'h0, 32'h66, 32'h0, ADD),
              fld(1, 0, 6, 7, 32'h0, 32'hCAFEF00D, 32'h0, ADD), 0);
        set_side(0, 5, 32'h99999999, 0, 0);
        cycle("byp_nowrite", fld(1, 5, 6, 7, 32'h55, 32'h66, 32'h0, ADD),
              fld(1, 5, 6, 7, 32'h55, 32'h66, 32'h0, ADD), 0);
        set_side(1, 5, 32'hAAAA5555, 0, 0);
        cycle("byp_both", fld(1, 5, 5, 7, 32'h1, 32'h2, 32'h10, ADD),
              fld(1, 5, 5, 7, 32'hAAAA5555, 32'hAAAA5555, 32'h10, ADD), 0);
        set_side(0, 0, 0, 0, 0);
    endtask

    task automatic test_flush();
        fld_t lw3, add3;
        lw3  = fld(1, 1, 8, 0, 32'h10, 32'h0, 32'h4, LW);
        add3 = fld(1, 8, 9, 3, 32'h77, 32'h88, 32'h0, ADD);
        cycle("fl_lw", lw3, lw3, 0);
        set_side(0, 0, 0, 1, 0);
        cycle("fl_squash", add3, '0, 0);
        check_cnt("fl_squash");
        set_side(0, 0, 0, 0, 0);
        cycle("fl_next", add3, add3, 0);
    endtask

    task automatic test_hold();
        fld_t lw4, add4;
        lw4  = fld(1, 1, 10, 0, 32'hA0, 32'h0, 32'h8, LW);
        add4 = fld(1, 10, 11, 12, 32'h1, 32'h2, 32'h0, ADD);
        cycle("hd_lw", lw4, lw4, 0);
        set_side(1, 1, 32'hBAD, 0, 1);
        for (int i = 0; i < 3; i++) cycle("hd_frozen", add4, lw4, 1);
        check_cnt("hd_frozen");
        set_side(0, 0, 0, 0, 0);
        cycle("hd_release_bubble", add4, '0, 1);
        exp_cnt++;
        check_cnt("hd_release_bubble");
        cycle("hd_capture", add4, add4, 0);
    endtask

    task automatic test_reset_mid_run();
        fld_t lw5, add5;
        lw5  = fld(1, 1, 13, 0, 32'hB0, 32'h0, 32'h0, LW);
        add5 = fld(1, 13, 2, 4, 32'h5, 32'h6, 32'h0, ADD);
        cycle("rst_lw", lw5, lw5, 0);
        drive_id(add5);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check_empty("rst_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle("rst_capture", add5, add5, 0);
        check_cnt("rst_capture");
    endtask

    task automatic test_saturate();
        fld_t lw6, add6;
        for (int i = 1; i <= 5; i++) begin
            lw6  = fld(1, 1, 14, 0, 32'(i), 32'h0, 32'h0, LW);
            add6 = fld(1, 14, 3, 5, 32'(i * 16), 32'h9, 32'h0, ADD);
            cycle("sat_lw", lw6, lw6, 0);
            cycle("sat_bubble", add6, '0, 1);
            exp_cnt++;
            check_cnt("sat_bubble");
            cycle("sat_capture", add6, add6, 0);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_reg0();
        test_bypass();
        test_flush();
        test_hold();
        test_reset_mid_run();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1);
    end

endmodule
